// File: rtl/tb_ctrl.sv
// Traceback scheduler: sequences decision writes into a 4-bank ring and drives the two traceback lanes.
// Optional macro TB_CTRL_PERF_CNT_EN adds the blk_cnt steady-state period counter output.
module tb_ctrl #(
    parameter int TB_LEN = 64,
    parameter int AW     = $clog2(TB_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          dec_valid,
    output logic          mem_wr_en,
    output logic [1:0]    mem_wr_bank,
    output logic [AW-1:0] mem_wr_addr,
    output logic [AW-1:0] mem_rd_addr,
    output logic [1:0]    mem_rd_bank_trn,
    output logic [1:0]    mem_rd_bank_dec,
    output logic          tbu_en_a,
    output logic          tbu_en_b,
    output logic          tbu_sel_a,
    output logic          tbu_sel_b,
    output logic          dec_ok,
    output logic          err
`ifdef TB_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]   blk_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_P2, S_RUN} state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_ptr, w_ptr_nxt;
    logic [AW-1:0] r_phase, w_phase_nxt;
    logic          r_a_trn, w_a_trn_nxt;
    logic          r_err, w_err_nxt;
    logic          r_en_a, r_en_b, r_sel_a, r_sel_b, r_dec_ok;

    logic w_accept, w_gap, w_wrap, w_trn_on, w_dec_on;

    // err only ever sets on the way to IDLE, so it alone blocks a restart.
    // rst gates acceptance so nothing is strobed while reset is held.
    assign w_accept = rst & enable & dec_valid & ~r_err;
    assign w_gap    = enable & ~dec_valid & (r_state != S_IDLE);
    assign w_wrap   = w_accept & (r_phase == AW'(TB_LEN - 1));
    assign w_trn_on = w_accept & (r_state inside {S_P1, S_P2, S_RUN});
    assign w_dec_on = w_accept & (r_state == S_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_phase <= '0;
            r_a_trn <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_phase <= w_phase_nxt;
            r_a_trn <= w_a_trn_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_phase_nxt = r_phase;
        w_a_trn_nxt = r_a_trn;
        w_err_nxt   = r_err;
        if (!enable || w_gap) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = 2'd0;
            w_phase_nxt = '0;
            w_a_trn_nxt = 1'b1;
            w_err_nxt   = enable;
        end else if (w_accept) begin
            w_phase_nxt = r_phase + AW'(1);
            if (r_state == S_IDLE)
                w_state_nxt = S_P0;
            if (w_wrap) begin
                w_ptr_nxt = r_ptr + 2'd1;
                // Lane A trains first in P1, so roles only start swapping after P1.
                if (r_state != S_P0)
                    w_a_trn_nxt = ~r_a_trn;
                case (r_state)
                    S_P0:    w_state_nxt = S_P1;
                    S_P1:    w_state_nxt = S_P2;
                    S_P2:    w_state_nxt = S_RUN;
                    default: w_state_nxt = r_state;
                endcase
            end
        end
    end

    assign mem_wr_en       = w_accept;
    assign mem_wr_bank     = w_accept ? r_ptr : 2'd0;
    assign mem_wr_addr     = w_accept ? r_phase : '0;
    assign mem_rd_addr     = w_accept ? (AW'(TB_LEN - 1) - r_phase) : '0;
    assign mem_rd_bank_trn = w_accept ? (r_ptr - 2'd1) : 2'd0;
    assign mem_rd_bank_dec = w_accept ? (r_ptr + 2'd1) : 2'd0;

    // One cycle behind the read address to line up with the synchronous RAM output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en_a   <= 1'b0;
            r_en_b   <= 1'b0;
            r_sel_a  <= 1'b0;
            r_sel_b  <= 1'b0;
            r_dec_ok <= 1'b0;
        end else begin
            r_en_a   <= r_a_trn ? w_trn_on : w_dec_on;
            r_en_b   <= r_a_trn ? w_dec_on : w_trn_on;
            r_sel_a  <= w_trn_on & ~r_a_trn;
            r_sel_b  <= w_trn_on & r_a_trn;
            r_dec_ok <= w_dec_on;
        end
    end

    assign tbu_en_a  = r_en_a;
    assign tbu_en_b  = r_en_b;
    assign tbu_sel_a = r_sel_a;
    assign tbu_sel_b = r_sel_b;
    assign dec_ok    = r_dec_ok;
    assign err       = r_err;

`ifdef TB_CTRL_PERF_CNT_EN
    logic [15:0] r_blk_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_blk_cnt <= 16'd0;
        else if (!enable)
            r_blk_cnt <= 16'd0;
        else if (w_wrap && r_state == S_RUN && r_blk_cnt != 16'hFFFF)
            r_blk_cnt <= r_blk_cnt + 16'd1;
    end

    assign blk_cnt = r_blk_cnt;
`endif

endmodule

// File: tb/tb_tb_ctrl.sv
// Self-checking bench for tb_ctrl at TB_LEN=8: vector table of per-word expectations plus
// a lane scoreboard, and hand-written sequences for reset, stream gap and enable drop.
module tb_tb_ctrl;
    localparam int TB_LEN = 8;
    localparam int AW     = 3;
    localparam int NV     = 56;

    typedef struct packed {
        logic en_a;
        logic en_b;
        logic sel_a;
        logic sel_b;
        logic dec_ok;
    } lane_t;

    typedef struct packed {
        logic [1:0]    wb;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [1:0]    tb;
        logic [1:0]    db;
        lane_t         ln;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, enable, dec_valid;
    logic          mem_wr_en;
    logic [1:0]    mem_wr_bank, mem_rd_bank_trn, mem_rd_bank_dec;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic          tbu_en_a, tbu_en_b, tbu_sel_a, tbu_sel_b, dec_ok, err;
`ifdef TB_CTRL_PERF_CNT_EN
    logic [15:0]   blk_cnt;
`endif

    tb_ctrl #(.TB_LEN(TB_LEN), .AW(AW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .dec_valid(dec_valid),
        .mem_wr_en(mem_wr_en), .mem_wr_bank(mem_wr_bank), .mem_wr_addr(mem_wr_addr),
        .mem_rd_addr(mem_rd_addr), .mem_rd_bank_trn(mem_rd_bank_trn),
        .mem_rd_bank_dec(mem_rd_bank_dec),
        .tbu_en_a(tbu_en_a), .tbu_en_b(tbu_en_b), .tbu_sel_a(tbu_sel_a),
        .tbu_sel_b(tbu_sel_b), .dec_ok(dec_ok), .err(err)
`ifdef TB_CTRL_PERF_CNT_EN
        , .blk_cnt(blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    nchk = 0;
    int    nerr = 0;
    lane_t sb[$];
    vec_t  tbl[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {19'd0, mem_wr_en, mem_wr_bank, mem_wr_addr, mem_rd_addr, mem_rd_bank_trn,
                mem_rd_bank_dec, tbu_en_a, tbu_en_b, tbu_sel_a, tbu_sel_b, dec_ok, err};
    endfunction

    // Apply words first..first+n-1 of a fresh stream back to back.
    task automatic run_words(input int first, input int n);
        lane_t e;
        enable    = 1'b1;
        dec_valid = 1'b1;
        for (int i = first; i < first + n; i++) begin
            @(negedge clk);
            chk($sformatf("mem[%0d]", i),
                {mem_wr_en, mem_wr_bank, mem_wr_addr, mem_rd_addr, mem_rd_bank_trn, mem_rd_bank_dec},
                {1'b1, tbl[i].wb, tbl[i].wa, tbl[i].ra, tbl[i].tb, tbl[i].db});
            sb.push_back(tbl[i].ln);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("lanes[%0d]", i),
                    {tbu_en_a, tbu_en_b, tbu_sel_a, tbu_sel_b, dec_ok, err}, {e, 1'b0});
            end
        end
    endtask

    initial begin
        for (int n = 0; n < NV; n++) begin
            int k;
            k = n / TB_LEN;
            tbl[n].wb = 2'(k % 4);
            tbl[n].wa = AW'(n % TB_LEN);
            tbl[n].ra = AW'(TB_LEN - 1 - (n % TB_LEN));
            tbl[n].tb = 2'((k + 3) % 4);
            tbl[n].db = 2'((k + 1) % 4);
            if (k == 0)      tbl[n].ln = 5'b00000;
            else if (k == 1) tbl[n].ln = 5'b10010;
            else if (k == 2) tbl[n].ln = 5'b01100;
            else if (((k - 3) % 2) == 0) tbl[n].ln = 5'b11011;
            else             tbl[n].ln = 5'b11101;
        end

        // Reset held with stimulus active.
        rst = 1'b0; enable = 1'b1; dec_valid = 1'b1;
        #12;
        chk("reset_outs", all_outs(), 0);
        @(posedge clk); #1;
        chk("reset_outs_held", all_outs(), 0);
        enable = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_rst", all_outs(), 0);
`ifdef TB_CTRL_PERF_CNT_EN
        chk("blk_cnt_reset", blk_cnt, 0);
`endif

        // Start-up, steady state, bank ring wrap and role swaps.
        run_words(0, NV);
`ifdef TB_CTRL_PERF_CNT_EN
        chk("blk_cnt_56", blk_cnt, 4);
`endif

        // Asynchronous reset in the middle of a RUN cycle.
        #3 rst = 1'b0;
        #1 chk("async_rst_outs", all_outs(), 0);
        @(posedge clk); #1;
        enable = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_async", all_outs(), 0);

        // Stream gap at word 13.
        run_words(0, 13);
        dec_valid = 1'b0;
        @(negedge clk);
        chk("gap_wr_en", mem_wr_en, 0);
        @(posedge clk); #1;
        chk("gap_lanes_err", {tbu_en_a, tbu_en_b, dec_ok, err}, 4'b0001);
        dec_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("blocked_wr_en", mem_wr_en, 0);
            @(posedge clk); #1;
            chk("err_sticky", {tbu_en_a, tbu_en_b, err}, 3'b001);
        end
        enable = 1'b0;
        @(posedge clk); #1;
        chk("err_cleared", err, 0);

        // Restart, reach RUN, then drop enable mid-RUN and restart again.
        run_words(0, 30);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("drop_lanes", {tbu_en_a, tbu_en_b, tbu_sel_a, tbu_sel_b, dec_ok, err}, 0);
`ifdef TB_CTRL_PERF_CNT_EN
        chk("blk_cnt_cleared", blk_cnt, 0);
`endif
        run_words(0, 25);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
